// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with FWFT byte FIFO; optional abort timer under PS2_TIMEOUT_EN
module ps2_frame_rx #(
  parameter int FIFO_AW = 2
`ifdef PS2_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50_000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk_i,
  input  logic               ps2_data_i,
  input  logic               rd_en_i,
  output logic [7:0]         code_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o,
  output logic               frame_err_o,
  output logic               overflow_o
);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
  state_e             state_q;
  logic [2:0]         clk_sync_q;
  logic [1:0]         data_sync_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic               par_q;
  logic               frame_err_q;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic               fall;
  logic               bit_d;
  logic               good;
  logic               push;
  logic               bad;
  logic               to_hit;
  logic               pop;
  logic               full;
  logic               wr;
  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_d = data_sync_q[1];
  assign good  = bit_d & (^{shift_q, par_q});
  assign push  = fall && state_q == STOP && good;
  assign bad   = fall && state_q == STOP && !good;
  assign pop   = rd_en_i && count_q != '0;
  assign full  = count_q == (FIFO_AW+1)'(DEPTH);
  assign wr    = push && (!full || pop);
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  assign to_hit = !fall && state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES);
  // Idle-time counter: restarts on every edge, runs only mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else to_q <= (fall || state_q == IDLE) ? '0 : to_q + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif
  // Two-stage synchronizers at the PS/2 idle level, third clock stage for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end
  // Deframing FSM: advances only on a detected falling edge of the PS/2 clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= bad | to_hit;
      if (to_hit) state_q <= IDLE;
      else if (fall) begin
        case (state_q)
          IDLE: if (!bit_d) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
          DATA: begin
            shift_q   <= {bit_d, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bit_d;
            state_q <= STOP;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  // FIFO storage, written only when the byte is accepted
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= shift_q;
  end
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_q + FIFO_AW'(wr);
      rptr_q  <= rptr_q + FIFO_AW'(pop);
      count_q <= count_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
      ovf_q   <= ovf_q | (push & full & !pop);
    end
  end
  assign code_o      = count_q == '0 ? 8'h00 : mem_q[rptr_q];
  assign empty_o     = count_q == '0;
  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: randomized scoreboard bench for ps2_frame_rx against a frame-level reference model
module tb_ps2_frame_rx;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 50_000;
  logic clk = 0;
  logic rst_n = 0;
  logic ps2_clk = 1;
  logic ps2_data = 1;
  logic rd_en = 0;
  logic [7:0] code;
  logic empty;
  logic [2:0] count;
  logic frame_err;
  logic overflow;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mf[$];
  bit exp_ovf = 0;
  int exp_err = 0;
  int err_seen = 0;
  int pos = 0;
  logic [10:0] fb = '0;
  logic prev_err = 0;

  always #10 clk = ~clk;

  ps2_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .rd_en_i(rd_en),
    .code_o(code), .empty_o(empty), .count_o(count), .frame_err_o(frame_err), .overflow_o(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (frame_err) begin
      err_seen++;
      chk("frame_err_width", int'(prev_err), 0);
    end
    prev_err = frame_err;
    if (rd_en) begin
      if (mf.size() == 0) chk("pop_on_empty", int'(empty), 1);
      else begin
        chk("pop_empty", int'(empty), 0);
        chk("pop_code", int'(code), int'(mf.pop_front()));
      end
    end
  end

  task automatic model_bit(input bit b);
    if (pos == 0) begin
      if (!b) begin
        fb[0] = 1'b0;
        pos = 1;
      end
    end else begin
      fb[pos] = b;
      pos++;
      if (pos == 11) begin
        pos = 0;
        if (fb[10] && (^fb[9:1])) begin
          if (mf.size() == DEPTH) exp_ovf = 1;
          else mf.push_back(fb[8:1]);
        end else exp_err++;
      end
    end
  endtask

  task automatic send_bit(input bit b, input bit pop_now = 0);
    @(negedge clk) ps2_data = b;
    repeat (8) @(negedge clk);
    ps2_clk = 0;
    @(posedge clk);
    @(posedge clk);
    if (pop_now) #1 rd_en = 1;
    @(posedge clk);
    #1 rd_en = 0;
    model_bit(b);
    repeat (8) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bp = 0, input bit bs = 0, input bit pop_last = 0);
    logic [10:0] f;
    f = {~bs, (~^d) ^ bp, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], pop_last && i == 10);
  endtask

  task automatic rd();
    @(posedge clk);
    #1 rd_en = 1;
    @(posedge clk);
    #1 rd_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 0;
    repeat (3) @(negedge clk);
    ps2_clk = 1;
    ps2_data = 1;
    mf.delete();
    pos = 0;
    exp_ovf = 0;
    prev_err = 0;
    rst_n = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
`ifdef PS2_TIMEOUT_EN
    if (n > TIMEOUT && pos != 0) begin
      pos = 0;
      exp_err++;
    end
`endif
  endtask

  task automatic check(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_count"}, int'(count), mf.size());
    chk({name, "_empty"}, int'(empty), int'(mf.size() == 0));
    chk({name, "_overflow"}, int'(overflow), int'(exp_ovf));
    chk({name, "_frame_err"}, err_seen, exp_err);
    chk({name, "_code"}, int'(code), mf.size() == 0 ? 0 : int'(mf[0]));
  endtask

  initial begin
    int r;
    do_reset();
    check("reset");
    send_frame(8'h1C);
    check("one_frame");
    rd();
    check("one_read");
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("two_frames");
    rd();
    check("two_read1");
    rd();
    check("two_read2");
    rd();
    check("read_empty");
    send_frame(8'h1C, 1, 0);
    check("bad_parity");
    send_frame(8'h1C, 0, 1);
    check("bad_stop");
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    check("overflow");
    repeat (4) rd();
    check("overflow_drain");
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(8'(i));
    send_frame(8'h05, 0, 0, 1);
    check("full_push_pop");
    repeat (4) rd();
    check("full_push_pop_drain");
    send_bit(0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    do_reset();
    send_frame(8'h32);
    check("reset_mid_frame");
    rd();
    send_bit(1);
    check("idle_glitch");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) send_frame(8'($urandom), r == 3, r == 4);
      else rd();
      if (i % 8 == 7) check("random");
    end
    repeat (4) rd();
    check("random_drain");
    do_reset();
    send_bit(0);
    send_bit(0);
    send_bit(0);
    send_bit(1);
    send_bit(1);
    idle(TIMEOUT + 100);
    check("timeout_gap");
    send_frame(8'h1C);
    check("after_gap");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
